// File: rtl/knn_local_sp_pkg.sv
// Shared defaults and grant encoding for the KNN local single-port memory arbiter.
package knn_local_sp_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 256;
    localparam int unsigned DEF_ADDR_WIDTH  = 11;
    localparam int unsigned DEF_MEM_LATENCY = 2;
    localparam int unsigned DEF_RESP_DEPTH  = 4;

    typedef enum logic [1:0] {
        GntNone = 2'd0,
        GntWr   = 2'd1,
        GntRd   = 2'd2
    } grant_e;

endpackage

// File: rtl/knn_sp_rsp_fifo.sv
// Read-response FIFO with a registered output stage; count includes the output register.
module knn_sp_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      arr_cnt_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  load, arr_rd, arr_wr, bypass;

    // The output register refills whenever it is empty or being consumed; an empty
    // array lets a fresh push go straight to the output.
    always_comb begin
        load   = !out_valid_q || out_ready;
        arr_rd = load && (arr_cnt_q != '0);
        bypass = load && (arr_cnt_q == '0) && push;
        arr_wr = push && !bypass;
    end

    always_ff @(posedge clk) begin
        if (arr_wr) store[wptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            arr_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (arr_wr) wptr_q <= wptr_q + PTR_W'(1);
            if (arr_rd) rptr_q <= rptr_q + PTR_W'(1);
            arr_cnt_q <= arr_cnt_q + CNT_W'(arr_wr) - CNT_W'(arr_rd);
            if (load) begin
                out_valid_q <= arr_rd || bypass;
                if (arr_rd) out_data_q <= store[rptr_q];
                else if (bypass) out_data_q <= push_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = arr_cnt_q + CNT_W'(out_valid_q);

    overflow_check: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == CNT_W'(DEPTH)) && !(out_valid_q && out_ready)));

endmodule

// File: rtl/knn_local_sp_arbiter.sv
// Round-robin write/read arbiter for one single-port memory with an in-order response FIFO.
// Define KNN_LOCAL_SP_ARB_STATS_EN to add saturating grant/stall counters.
module knn_local_sp_arbiter
    import knn_local_sp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int unsigned RESP_DEPTH  = DEF_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_address0,
    output logic                  mem_ce0,
    output logic                  mem_we0,
    output logic [DATA_WIDTH-1:0] mem_d0,
    input  logic [DATA_WIDTH-1:0] mem_q0
`ifdef KNN_LOCAL_SP_ARB_STATS_EN
    ,
    output logic [31:0]           stat_wr,
    output logic [31:0]           stat_rd,
    output logic [31:0]           stat_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    grant_e               grant;
    logic                 rd_pri_q, rd_pri_d;
    logic [MEM_LATENCY-1:0] vld_q;
    logic [CNT_W-1:0]     fifo_count;
    logic [SUM_W-1:0]     inflight;
    logic                 rd_elig, conflict;

    // Reads already issued plus buffered responses must leave a free FIFO slot.
    always_comb begin
        inflight = SUM_W'(fifo_count);
        for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + SUM_W'(vld_q[i]);
        rd_elig  = inflight < SUM_W'(RESP_DEPTH);
    end

    always_comb begin
        grant    = GntNone;
        conflict = wr_valid && rd_valid && rd_elig;
        rd_pri_d = rd_pri_q;
        if (reset) begin
            if (rd_valid && rd_elig && (!wr_valid || rd_pri_q)) grant = GntRd;
            else if (wr_valid) grant = GntWr;
            if (conflict) rd_pri_d = (grant == GntWr);
        end
    end

    always_comb begin
        wr_ready     = (grant == GntWr);
        rd_ready     = (grant == GntRd);
        mem_ce0      = (grant != GntNone);
        mem_we0      = (grant == GntWr);
        mem_address0 = (grant == GntWr) ? wr_addr : rd_addr;
        mem_d0       = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pri_q <= 1'b1;
            vld_q    <= '0;
        end else begin
            rd_pri_q <= rd_pri_d;
            vld_q[0] <= (grant == GntRd);
            for (int i = 1; i < MEM_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    knn_sp_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_q[MEM_LATENCY-1]),
        .push_data (mem_q0),
        .out_ready (rsp_ready),
        .out_valid (rsp_valid),
        .out_data  (rsp_data),
        .count     (fifo_count)
    );

`ifdef KNN_LOCAL_SP_ARB_STATS_EN
    logic stall;
    assign stall = (wr_valid && grant != GntWr) || (rd_valid && grant != GntRd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_wr    <= '0;
            stat_rd    <= '0;
            stat_stall <= '0;
        end else begin
            if (grant == GntWr && stat_wr != '1) stat_wr <= stat_wr + 32'd1;
            if (grant == GntRd && stat_rd != '1) stat_rd <= stat_rd + 32'd1;
            if (stall && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_knn_local_sp_arbiter.sv
// Directed self-checking bench for knn_local_sp_arbiter with a 2-cycle memory model.
module tb_knn_local_sp_arbiter;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid = 1'b0, rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid, rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0, mem_we0;
    logic [DW-1:0] mem_d0, mem_q0 = '0;
`ifdef KNN_LOCAL_SP_ARB_STATS_EN
    logic [31:0]   stat_wr, stat_rd, stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd    = 0;
    int n_wr    = 0;
    logic [DW-1:0] got[$];

    always #5 clk = ~clk;

    knn_local_sp_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .mem_address0 (mem_address0),
        .mem_ce0      (mem_ce0),
        .mem_we0      (mem_we0),
        .mem_d0       (mem_d0),
        .mem_q0       (mem_q0)
`ifdef KNN_LOCAL_SP_ARB_STATS_EN
        ,
        .stat_wr      (stat_wr),
        .stat_rd      (stat_rd),
        .stat_stall   (stat_stall)
`endif
    );

    // Single-port RAM, read data valid two cycles after the strobe.
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] rd_pipe = '0;
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) ram[mem_address0] <= mem_d0;
        if (mem_ce0 && !mem_we0) rd_pipe <= ram[mem_address0];
        mem_q0 <= rd_pipe;
    end

    always @(posedge clk) begin
        if (reset && rsp_valid && rsp_ready) got.push_back(rsp_data);
        if (reset && rd_valid && rd_ready) n_rd++;
        if (reset && wr_valid && wr_ready) n_wr++;
    end

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'h5A5A_0000 ^ 32'(i);
        return {8{w}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;

        // Reset: requests pending but nothing may be granted.
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_ready", DW'(wr_ready), DW'(0));
        check("rst_rd_ready", DW'(rd_ready), DW'(0));
        check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("rst_mem_ce0", DW'(mem_ce0), DW'(0));
        check("rst_mem_we0", DW'(mem_we0), DW'(0));

        // Both valid every cycle: RD, WR, RD, WR ... starting right after release.
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = AW'(100 + i);
            wr_data = pat(100 + i);
            rd_addr = '0;
            #1;
            check($sformatf("alt_rd_ready_%0d", i), DW'(rd_ready), DW'((i % 2) == 0));
            check($sformatf("alt_wr_ready_%0d", i), DW'(wr_ready), DW'((i % 2) == 1));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        check("alt_n_rd", DW'(n_rd), DW'(4));
        check("alt_n_wr", DW'(n_wr), DW'(4));
        repeat (6) @(negedge clk);
        got.delete();

        // Write then read the top address; response 3 cycles after the read grant.
        wr_valid = 1'b1;
        wr_addr  = 11'h7FF;
        wr_data  = {32{8'hA5}};
        #1;
        check("wa_wr_ready", DW'(wr_ready), DW'(1));
        check("wa_mem_we0", DW'(mem_we0), DW'(1));
        check("wa_mem_addr", DW'(mem_address0), DW'(11'h7FF));
        check("wa_mem_d0", mem_d0, {32{8'hA5}});
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 11'h7FF;
        #1;
        check("ra_rd_ready", DW'(rd_ready), DW'(1));
        check("ra_mem_ce0", DW'(mem_ce0), DW'(1));
        check("ra_mem_we0", DW'(mem_we0), DW'(0));
        check("ra_mem_addr", DW'(mem_address0), DW'(11'h7FF));
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        check("ra_rsp_lat1", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        #1;
        check("ra_rsp_lat2", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        #1;
        check("ra_rsp_lat3", DW'(rsp_valid), DW'(1));
        check("ra_rsp_data", rsp_data, {32{8'hA5}});
        repeat (3) @(negedge clk);
        got.delete();

        // Preload addresses 0..99 with known patterns.
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = pat(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;

        // Backpressure: only 4 reads fit, then a pending write still goes through.
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_addr = AW'(10 + i);
            #1;
            check($sformatf("bp_rd_ready_%0d", i), DW'(rd_ready), DW'(i < 4));
            @(negedge clk);
        end
        wr_valid = 1'b1;
        wr_addr  = AW'(300);
        wr_data  = pat(300);
        #1;
        check("bp_wr_ready", DW'(wr_ready), DW'(1));
        check("bp_rd_blocked", DW'(rd_ready), DW'(0));
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        #1;
        check("bp_rsp_valid", DW'(rsp_valid), DW'(1));
        check("bp_rsp_data", rsp_data, pat(10));
        @(negedge clk);
        #1;
        check("bp_rsp_hold", rsp_data, pat(10));
        rsp_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_rsp_count", DW'(got.size()), DW'(4));
        for (int i = 0; i < got.size(); i++) check($sformatf("bp_rsp_%0d", i), got[i], pat(10 + i));
        got.delete();

        // 100 back-to-back reads with rsp_ready toggling.
        k   = 0;
        cyc = 0;
        rd_valid = 1'b1;
        while (k < 100 && cyc < 1000) begin
            rd_addr   = AW'(k);
            rsp_ready = (cyc % 2) == 0;
            #1;
            if (rd_ready) k++;
            @(negedge clk);
            cyc++;
        end
        rd_valid = 1'b0;
        while (got.size() < 100 && cyc < 2000) begin
            rsp_ready = (cyc % 2) == 0;
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("b2b_granted", DW'(k), DW'(100));
        check("b2b_rsp_count", DW'(got.size()), DW'(100));
        for (int i = 0; i < got.size(); i++) check($sformatf("b2b_rsp_%0d", i), got[i], pat(i));
        got.delete();

        // Reset with two reads in flight: nothing stale may come out afterwards.
        rd_valid = 1'b1;
        rd_addr  = AW'(5);
        @(negedge clk);
        rd_addr = AW'(6);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rd_ready", DW'(rd_ready), DW'(0));
        check("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
        repeat (2) @(negedge clk);
        rd_valid = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("post_rst_rsp_%0d", i), DW'(rsp_valid), DW'(0));
            @(negedge clk);
        end
        check("post_rst_none", DW'(got.size()), DW'(0));
        rd_valid = 1'b1;
        rd_addr  = AW'(7);
        #1;
        check("post_rst_rd_ready", DW'(rd_ready), DW'(1));
        @(negedge clk);
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_new_valid", DW'(rsp_valid), DW'(1));
        check("post_rst_new_data", rsp_data, pat(7));
        repeat (3) @(negedge clk);

`ifdef KNN_LOCAL_SP_ARB_STATS_EN
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("st_rst_wr", DW'(stat_wr), DW'(0));
        check("st_rst_rd", DW'(stat_rd), DW'(0));
        check("st_rst_stall", DW'(stat_stall), DW'(0));
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        repeat (10) @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        #1;
        check("st_stall", DW'(stat_stall), DW'(10));
        check("st_total", DW'(stat_rd + stat_wr), DW'(10));
        check("st_rd", DW'(stat_rd), DW'(5));
        repeat (4) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
